// File: rtl/juego_pkg.sv
// Shared definitions for the tic-tac-toe sequencer: cell/winner codes, FSM states and the line table.
package juego_pkg;

    localparam logic [1:0] VACIO     = 2'b00;
    localparam logic [1:0] CASILLA_X = 2'b11;
    localparam logic [1:0] CASILLA_O = 2'b01;

    localparam logic [1:0] GAN_NINGUNO = 2'b00;
    localparam logic [1:0] GAN_P1      = 2'b01;
    localparam logic [1:0] GAN_P2      = 2'b10;

    typedef enum logic [2:0] {
        ST_INICIO   = 3'd0,
        ST_TURNO_P1 = 3'd1,
        ST_TURNO_P2 = 3'd2,
        ST_EVAL_P1  = 3'd3,
        ST_EVAL_P2  = 3'd4,
        ST_FIN      = 3'd5
    } estado_t;

    // Cell indices (c1 = 0) of each line; entry order matches linea_ganadora bit order.
    localparam logic [3:0] LINEAS [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/detector_ganador.sv
// Combinational three-in-a-row check for one player code over the nine stored cells.
module detector_ganador
    import juego_pkg::*;
(
    input  logic [8:0][1:0] celdas,
    input  logic [1:0]      jugador,
    output logic            hay_ganador,
    output logic [7:0]      linea
);

    always_comb begin
        linea = '0;
        for (int l = 0; l < 8; l++) begin
            linea[l] = (jugador != VACIO) &&
                       (celdas[LINEAS[l][0]] == jugador) &&
                       (celdas[LINEAS[l][1]] == jugador) &&
                       (celdas[LINEAS[l][2]] == jugador);
        end
    end

    assign hay_ganador = |linea;

endmodule

// File: rtl/control_turnos.sv
// Tic-tac-toe game sequencer: grants turns, counts moves, detects win/draw, per-turn timeout, restart.
//
// state    | meaning
// INICIO   | clear game results, hand the first turn to P1
// TURNO_P1 | waiting for P1's move (or its timeout)
// TURNO_P2 | waiting for P2's move (or its timeout)
// EVAL_P1  | one cycle: count P1's move, check win/draw
// EVAL_P2  | one cycle: count P2's move, check win/draw
// FIN      | game over, results held until restart
module control_turnos
    import juego_pkg::*;
#(
    parameter logic [31:0] TIEMPO_TURNO = 32'd0,
    parameter int          ANCHO_CONT   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p1_mm,
    input  logic       p2_mm,
    input  logic [1:0] guarda_c1,
    input  logic [1:0] guarda_c2,
    input  logic [1:0] guarda_c3,
    input  logic [1:0] guarda_c4,
    input  logic [1:0] guarda_c5,
    input  logic [1:0] guarda_c6,
    input  logic [1:0] guarda_c7,
    input  logic [1:0] guarda_c8,
    input  logic [1:0] guarda_c9,
    input  logic       boton_reinicio,
    output logic       turno_p1,
    output logic       turno_p2,
    output logic [1:0] ganador,
    output logic       empate,
    output logic       fin_juego,
    output logic [3:0] num_jugadas,
    output logic [7:0] linea_ganadora,
    output logic       limpiar_tablero
);

    localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(TIEMPO_TURNO - 32'd1);

    estado_t               r_estado;
    logic                  r_p1_mm_q, r_p2_mm_q;
    logic [ANCHO_CONT-1:0] r_cont;
    logic                  r_turno_p1, r_turno_p2, r_empate, r_fin, r_limpiar;
    logic [1:0]            r_ganador;
    logic [3:0]            r_num;
    logic [7:0]            r_linea;

    logic                  w_ev1, w_ev2, w_timeout, w_hay_ganador;
    logic [1:0]            w_jugador;
    logic [7:0]            w_linea;
    logic [8:0][1:0]       w_celdas;

    assign w_ev1     = p1_mm & ~r_p1_mm_q;
    assign w_ev2     = p2_mm & ~r_p2_mm_q;
    assign w_timeout = (TIEMPO_TURNO != 32'd0) && (r_cont == LIMITE);
    assign w_jugador = (r_estado == ST_EVAL_P2) ? CASILLA_O : CASILLA_X;
    assign w_celdas  = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                        guarda_c4, guarda_c3, guarda_c2, guarda_c1};

    detector_ganador u_detector (
        .celdas      (w_celdas),
        .jugador     (w_jugador),
        .hay_ganador (w_hay_ganador),
        .linea       (w_linea)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= ST_INICIO;
            r_p1_mm_q  <= 1'b0;
            r_p2_mm_q  <= 1'b0;
            r_cont     <= '0;
            r_turno_p1 <= 1'b0;
            r_turno_p2 <= 1'b0;
            r_ganador  <= GAN_NINGUNO;
            r_empate   <= 1'b0;
            r_fin      <= 1'b0;
            r_num      <= 4'd0;
            r_linea    <= 8'd0;
            r_limpiar  <= 1'b0;
        end else begin
            r_p1_mm_q <= p1_mm;
            r_p2_mm_q <= p2_mm;
            r_limpiar <= 1'b0;
            case (r_estado)
                ST_INICIO: begin
                    r_estado   <= ST_TURNO_P1;
                    r_turno_p1 <= 1'b1;
                    r_turno_p2 <= 1'b0;
                    r_cont     <= '0;
                    r_num      <= 4'd0;
                    r_ganador  <= GAN_NINGUNO;
                    r_empate   <= 1'b0;
                    r_linea    <= 8'd0;
                    r_fin      <= 1'b0;
                end
                ST_TURNO_P1, ST_TURNO_P2: begin
                    // A move beats a timeout landing on the same cycle.
                    if ((r_estado == ST_TURNO_P1) ? w_ev1 : w_ev2) begin
                        r_estado   <= (r_estado == ST_TURNO_P1) ? ST_EVAL_P1 : ST_EVAL_P2;
                        r_turno_p1 <= 1'b0;
                        r_turno_p2 <= 1'b0;
                    end else if (w_timeout) begin
                        r_estado   <= (r_estado == ST_TURNO_P1) ? ST_TURNO_P2 : ST_TURNO_P1;
                        r_turno_p1 <= (r_estado == ST_TURNO_P2);
                        r_turno_p2 <= (r_estado == ST_TURNO_P1);
                        r_cont     <= '0;
                    end else if (r_cont != '1) begin
                        r_cont <= r_cont + ANCHO_CONT'(1);
                    end
                end
                ST_EVAL_P1, ST_EVAL_P2: begin
                    r_num <= r_num + 4'd1;
                    if (w_hay_ganador) begin
                        r_estado  <= ST_FIN;
                        r_ganador <= (r_estado == ST_EVAL_P1) ? GAN_P1 : GAN_P2;
                        r_linea   <= w_linea;
                        r_fin     <= 1'b1;
                    end else if (r_num == 4'd8) begin
                        r_estado <= ST_FIN;
                        r_empate <= 1'b1;
                        r_fin    <= 1'b1;
                    end else begin
                        r_estado   <= (r_estado == ST_EVAL_P1) ? ST_TURNO_P2 : ST_TURNO_P1;
                        r_turno_p1 <= (r_estado == ST_EVAL_P2);
                        r_turno_p2 <= (r_estado == ST_EVAL_P1);
                        r_cont     <= '0;
                    end
                end
                ST_FIN: begin
                    if (boton_reinicio) begin
                        r_estado  <= ST_INICIO;
                        r_limpiar <= 1'b1;
                        r_fin     <= 1'b0;
                        r_num     <= 4'd0;
                        r_ganador <= GAN_NINGUNO;
                        r_empate  <= 1'b0;
                        r_linea   <= 8'd0;
                    end
                end
                default: begin
                    r_estado   <= ST_INICIO;
                    r_turno_p1 <= 1'b0;
                    r_turno_p2 <= 1'b0;
                    r_fin      <= 1'b0;
                    r_cont     <= '0;
                end
            endcase
        end
    end

    assign turno_p1        = r_turno_p1;
    assign turno_p2        = r_turno_p2;
    assign ganador         = r_ganador;
    assign empate          = r_empate;
    assign fin_juego       = r_fin;
    assign num_jugadas     = r_num;
    assign linea_ganadora  = r_linea;
    assign limpiar_tablero = r_limpiar;

endmodule
